// File: rtl/ifu_pkg.sv
// Shared IFU defines (bus widths, EBREAK encoding) and the fetch FSM state type.
// The optional response check is enabled by defining IFU_RRESP_CHECK_EN.
`ifndef IFU_DEFINES_SV
`define IFU_DEFINES_SV
`define INST_ADDR_BUS 31:0
`define INST_DATA_BUS 31:0
`define INST_EBREAK   32'h00100073
`endif

package ifu_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_OUT  = 2'd3
    } ifu_state_e;

    localparam logic [1:0] RRESP_OKAY = 2'b00;
endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding read per fetch, IDLE -> AR -> R -> OUT.
// IFU_RRESP_CHECK_EN: a non-OKAY read response loads EBREAK and raises inst_fault.
module ifu
    import ifu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req,
    input  logic [`INST_ADDR_BUS] fetch_pc,
    output logic                  fetch_ready,
    output logic [`INST_DATA_BUS] inst,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic                  inst_fault,
    output logic [`INST_ADDR_BUS] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [`INST_DATA_BUS] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);
    ifu_state_e            state_q;
    logic [`INST_ADDR_BUS] pc_q;
    logic [`INST_DATA_BUS] inst_q;

`ifdef IFU_RRESP_CHECK_EN
    logic fault_q;
`else
    logic rresp_unused;
    assign rresp_unused = ^rresp;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            inst_q  <= '0;
`ifdef IFU_RRESP_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (fetch_req) begin
                    pc_q    <= fetch_pc;
                    state_q <= S_AR;
                end
                S_AR: if (arready) state_q <= S_R;
                S_R: if (rvalid) begin
`ifdef IFU_RRESP_CHECK_EN
                    inst_q  <= (rresp != RRESP_OKAY) ? `INST_EBREAK : rdata;
                    fault_q <= (rresp != RRESP_OKAY);
`else
                    inst_q  <= rdata;
`endif
                    state_q <= S_OUT;
                end
                // Consumption and a new request in the same cycle skip IDLE.
                S_OUT: if (inst_ready) begin
                    if (fetch_req) begin
                        pc_q    <= fetch_pc;
                        state_q <= S_AR;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fetch_ready = (state_q == S_IDLE) || ((state_q == S_OUT) && inst_ready);
    assign arvalid     = (state_q == S_AR);
    assign rready      = (state_q == S_R);
    assign inst_valid  = (state_q == S_OUT);
    assign araddr      = pc_q;
    assign inst        = inst_q;
`ifdef IFU_RRESP_CHECK_EN
    assign inst_fault  = fault_q;
`else
    assign inst_fault  = 1'b0;
`endif
endmodule

// File: tb/tb_ifu.sv
// IFU bench: directed latency/stall/reset scenarios, then random traffic checked
// by a transaction scoreboard (expected addresses and instructions in queues).
module tb_ifu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        inst_fault;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    typedef struct { logic [31:0] data; logic fault; } exp_inst_t;
    logic [31:0] q_addr[$];
    exp_inst_t   q_inst[$];

    ifu dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
        .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_fault(inst_fault),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // What the core should see for a read with response rr and data rd.
    function automatic exp_inst_t expect_read(input logic [31:0] rd, input logic [1:0] rr);
        exp_inst_t e;
`ifdef IFU_RRESP_CHECK_EN
        e.data  = (rr != 2'b00) ? 32'h00100073 : rd;
        e.fault = (rr != 2'b00);
`else
        e.data  = rd;
        e.fault = 1'b0;
        if (rr == 2'b11) e.fault = 1'b0;
`endif
        return e;
    endfunction

    // Scoreboard monitor: handshakes are judged at negedge, ahead of the edge that takes them.
    logic [31:0] prev_araddr;
    logic [31:0] prev_inst;
    bit          ar_pending = 1'b0;
    bit          out_pending = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("one_hot", 32'(arvalid) + 32'(rready) + 32'(inst_valid) <= 1, 32'd1);
            chk("fetch_ready_rule", {31'd0, fetch_ready},
                {31'd0, !arvalid && !rready && (!inst_valid || inst_ready)});
            if (arvalid && ar_pending) chk("araddr_stable", araddr, prev_araddr);
            if (inst_valid && out_pending) chk("inst_stable", inst, prev_inst);
            if (arvalid && arready) begin
                if (q_addr.size() == 0) chk("araddr_unexpected", 32'd1, 32'd0);
                else chk("araddr", araddr, q_addr.pop_front());
            end
            if (rvalid && rready) q_inst.push_back(expect_read(rdata, rresp));
            if (inst_valid && inst_ready) begin
                if (q_inst.size() == 0) chk("inst_unexpected", 32'd1, 32'd0);
                else begin
                    exp_inst_t e;
                    e = q_inst.pop_front();
                    chk("inst", inst, e.data);
                    chk("inst_fault", {31'd0, inst_fault}, {31'd0, e.fault});
                end
            end
            if (fetch_req && fetch_ready) q_addr.push_back(fetch_pc);
            ar_pending  = arvalid && !arready;
            prev_araddr = araddr;
            out_pending = inst_valid && !inst_ready;
            prev_inst   = inst;
        end
    end

    initial begin
        exp_inst_t e;
        logic [31:0] held;
        rst_n = 1'b0; fetch_req = 0; fetch_pc = '0; inst_ready = 0;
        arready = 0; rdata = '0; rresp = 2'b00; rvalid = 0;
        #12;
        chk("rst_fetch_ready", {31'd0, fetch_ready}, 32'd1);
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_rready", {31'd0, rready}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_fault", {31'd0, inst_fault}, 32'd0);
        rst_n = 1'b1;
        cyc();

        // Minimum-latency fetch
        fetch_req = 1; fetch_pc = 32'h8000_0000; arready = 1; rvalid = 1; rdata = 32'h0000_0413;
        chk("lat_fetch_ready", {31'd0, fetch_ready}, 32'd1);
        cyc(); fetch_req = 0;
        chk("lat_arvalid", {31'd0, arvalid}, 32'd1);
        chk("lat_araddr", araddr, 32'h8000_0000);
        chk("lat_fetch_ready_ar", {31'd0, fetch_ready}, 32'd0);
        cyc();
        chk("lat_rready", {31'd0, rready}, 32'd1);
        cyc();
        chk("lat_inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("lat_inst", inst, 32'h0000_0413);

        // Core stalls in OUT while read data keeps changing
        for (int i = 0; i < 3; i++) begin
            rdata = $urandom;
            cyc();
            chk("hold_inst_valid", {31'd0, inst_valid}, 32'd1);
            chk("hold_inst", inst, 32'h0000_0413);
        end

        // Consume and request in the same cycle: straight to AR
        inst_ready = 1; fetch_req = 1; fetch_pc = 32'h8000_0004; arready = 0;
        #1 chk("b2b_fetch_ready", {31'd0, fetch_ready}, 32'd1);
        cyc(); fetch_req = 1; inst_ready = 0;
        chk("b2b_arvalid", {31'd0, arvalid}, 32'd1);
        chk("b2b_araddr", araddr, 32'h8000_0004);

        // Address phase stalled for four cycles
        for (int i = 0; i < 4; i++) begin
            fetch_pc = $urandom;
            cyc();
            chk("stall_arvalid", {31'd0, arvalid}, 32'd1);
            chk("stall_araddr", araddr, 32'h8000_0004);
            chk("stall_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        end
        fetch_req = 0; arready = 1; rvalid = 0;
        cyc();
        chk("stall_rready", {31'd0, rready}, 32'd1);
        cyc();
        chk("r_wait_rready", {31'd0, rready}, 32'd1);
        rvalid = 1; rresp = 2'b10; rdata = 32'hdead_beef;
        cyc(); rresp = 2'b00;
        e = expect_read(32'hdead_beef, 2'b10);
        chk("err_inst", inst, e.data);
        chk("err_fault", {31'd0, inst_fault}, {31'd0, e.fault});
        inst_ready = 1;
        cyc(); inst_ready = 0;
        chk("idle_fetch_ready", {31'd0, fetch_ready}, 32'd1);
        chk("idle_inst_valid", {31'd0, inst_valid}, 32'd0);

        // Reset while waiting for read data
        fetch_req = 1; fetch_pc = 32'h0000_0100; rvalid = 0;
        cyc(); fetch_req = 0;
        cyc();
        chk("pre_rst_rready", {31'd0, rready}, 32'd1);
        rst_n = 0;
        #1;
        chk("mid_rst_rready", {31'd0, rready}, 32'd0);
        chk("mid_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("mid_rst_fetch_ready", {31'd0, fetch_ready}, 32'd1);
        chk("mid_rst_inst", inst, 32'd0);
        chk("mid_rst_fault", {31'd0, inst_fault}, 32'd0);
        cyc(); rst_n = 1;
        cyc();
        fetch_req = 1; fetch_pc = 32'h0000_0200; rvalid = 1; rdata = 32'h0000_0013;
        cyc(); fetch_req = 0;
        chk("post_rst_araddr", araddr, 32'h0000_0200);
        cyc(); cyc();
        chk("post_rst_inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("post_rst_inst", inst, 32'h0000_0013);
        inst_ready = 1; rvalid = 0;
        cyc();
        held = {31'd0, inst_valid};
        chk("post_rst_consumed", held, 32'd0);

        // Random traffic against the scoreboard
        mon_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            fetch_req  = $urandom_range(0, 1);
            fetch_pc   = $urandom;
            arready    = $urandom_range(0, 2) != 0;
            rvalid     = $urandom_range(0, 2) != 0;
            rdata      = $urandom;
            rresp      = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'($urandom_range(1, 3));
            inst_ready = $urandom_range(0, 2) != 0;
            cyc();
        end
        fetch_req = 0; arready = 1; rvalid = 1; inst_ready = 1;
        for (int i = 0; i < 8; i++) cyc();
        mon_en = 1'b0;
        chk("drain_addr_q", q_addr.size(), 32'd0);
        chk("drain_inst_q", q_inst.size(), 32'd0);
        chk("drain_idle", {31'd0, fetch_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
